// File: rtl/program_loader_if.sv
// Boot loader bundle: the byte stream in, the instruction-memory write port out, and the core-control flags.
// The slave modport is the loader; the master modport is whatever feeds it the stream and watches the results.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              eop;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              load_busy;
  logic              load_err;

  modport master (
    output in_data, in_valid, eop,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, load_busy, load_err
  );

  modport slave (
    input  in_data, in_valid, eop,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, load_busy, load_err
  );
endinterface

// File: rtl/program_loader.sv
// Assembles a checksummed byte stream into 16-bit words and writes them to instruction memory.
// The core is held in reset until a complete program has passed its checksum.
module program_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic             CLK,
  input  logic             RST,
  program_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_HDR_LO, S_HDR_HI, S_DAT_LO, S_DAT_HI, S_CHK, S_RUN, S_ERR
  } state_e;

  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [7:0]        lo_q, lo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              load_err_q, load_err_d;

  logic              in_ready;
  logic              xfer;
  logic [15:0]       hdr_n;
  logic              hdr_bad;
  logic              last_word;

  assign in_ready  = (state_q inside {S_HDR_LO, S_HDR_HI, S_DAT_LO, S_DAT_HI, S_CHK});
  assign xfer      = bus.in_valid && in_ready;
  assign hdr_n     = {bus.in_data, count_q[7:0]};
  assign hdr_bad   = (hdr_n == 16'd0) || (32'(hdr_n) > MAX_WORDS);
  // The index is one bit wider than the address so a full-size program does not wrap.
  assign last_word = (16'(idx_q) == (count_q - 16'd1));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    count_d   = count_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      S_HDR_LO: if (xfer) begin
        count_d[7:0] = bus.in_data;
        chk_d        = bus.in_data;
        state_d      = S_HDR_HI;
      end
      S_HDR_HI: if (xfer) begin
        count_d[15:8] = bus.in_data;
        chk_d         = chk_q ^ bus.in_data;
        if (hdr_bad) begin
          state_d = S_ERR;
        end else begin
          idx_d   = '0;
          state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: if (xfer) begin
        lo_d    = bus.in_data;
        chk_d   = chk_q ^ bus.in_data;
        state_d = S_DAT_HI;
      end
      S_DAT_HI: if (xfer) begin
        chk_d   = chk_q ^ bus.in_data;
        we_d    = 1'b1;
        addr_d  = idx_q[ADDR_W-1:0];
        wdata_d = {bus.in_data, lo_q};
        if (last_word) begin
          state_d = S_CHK;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_DAT_LO;
        end
      end
      S_CHK: if (xfer) begin
        state_d = (bus.in_data == chk_q) ? S_RUN : S_ERR;
      end
      S_RUN: if (bus.eop) begin
        state_d = S_HDR_LO;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HDR_LO;
    endcase

    // The core runs only while the loader sits in RUN; the error flag tracks entry to ERR.
    cpu_rst_n_d = (state_d == S_RUN);
    load_err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_HDR_LO;
      count_q     <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      lo_q        <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      count_q     <= count_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      load_err_q  <= load_err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.load_busy  = (state_q inside {S_HDR_HI, S_DAT_LO, S_DAT_HI, S_CHK});
  assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a stream-level model predicts writes and outcome,
// and a negedge monitor compares every imem_we pulse against the expected-write queue.
module tb_program_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  wr_t exp_q[$];
  wr_t mon_w;
  int  tests_run    = 0;
  int  tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst_n && bus.imem_we) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_w = exp_q.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(mon_w.addr));
        check("wr_data", 32'(bus.imem_wdata), 32'(mon_w.data));
      end
    end
  end

  // Stream-level reference: parse header, queue the writes, decide pass/fail and how many bytes get consumed.
  task automatic model(input logic [7:0] s[$], output bit ok, output int n_acc);
    int         n;
    logic [7:0] x;
    wr_t        w;
    n = int'({s[1], s[0]});
    if (n == 0 || n > MAX_WORDS) begin
      ok    = 1'b0;
      n_acc = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w.addr = 8'(i);
      w.data = {s[3 + 2*i], s[2 + 2*i]};
      exp_q.push_back(w);
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 2*n; i++) x = x ^ s[i];
    ok    = (s[2 + 2*n] == x);
    n_acc = 3 + 2*n;
  endtask

  task automatic make_stream(input int n_hdr, input int n_words, input bit corrupt,
                             output logic [7:0] s[$]);
    logic [7:0] x;
    logic [7:0] b;
    s = {};
    b = 8'(n_hdr);
    s.push_back(b);
    b = 8'(n_hdr >> 8);
    s.push_back(b);
    for (int i = 0; i < 2*n_words; i++) begin
      b = 8'($urandom);
      s.push_back(b);
    end
    x = 8'h00;
    foreach (s[i]) x = x ^ s[i];
    if (corrupt) x = x ^ 8'($urandom_range(1, 255));
    s.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit e, input bit gap,
                           output bit busy_before, output bit rstn_before);
    int waited = 0;
    if (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    bus.eop      = e;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    busy_before = bus.load_busy;
    rstn_before = bus.cpu_rst_n;
    if (!bus.in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL ready_timeout: got in_ready 0 for %0d cycles expected 1", waited);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic run_stream(input string name, input logic [7:0] s[$], input bit gaps,
                            input int eop_bytes, output bit ok);
    int n_acc;
    bit busy_b, rstn_b;
    model(s, ok, n_acc);
    for (int i = 0; i < n_acc; i++) begin
      send_byte(s[i], (i < eop_bytes), gaps && (i > 0), busy_b, rstn_b);
      if (i == 0) check({name, "_busy_idle"}, 32'(busy_b), 32'd0);
      if (i == n_acc - 1) begin
        check({name, "_busy_last"}, 32'(busy_b), 32'd1);
        check({name, "_rstn_held"}, 32'(rstn_b), 32'd0);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.eop      = 1'b0;
    check({name, "_cpu_rst_n"}, 32'(bus.cpu_rst_n), 32'(ok));
    check({name, "_load_err"},  32'(bus.load_err),  32'(!ok));
    check({name, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({name, "_load_busy"}, 32'(bus.load_busy), 32'd0);
    repeat (2) @(negedge clk);
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic release_run(input string name);
    @(negedge clk);
    bus.eop = 1'b1;
    @(negedge clk);
    bus.eop = 1'b0;
    check({name, "_eop_rstn"},  32'(bus.cpu_rst_n), 32'd0);
    check({name, "_eop_ready"}, 32'(bus.in_ready),  32'd1);
    check({name, "_eop_busy"},  32'(bus.load_busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_in_ready"},   32'(bus.in_ready),   32'd1);
    check({name, "_imem_we"},    32'(bus.imem_we),    32'd0);
    check({name, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
    check({name, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
    check({name, "_cpu_rst_n"},  32'(bus.cpu_rst_n),  32'd0);
    check({name, "_load_busy"},  32'(bus.load_busy),  32'd0);
    check({name, "_load_err"},   32'(bus.load_err),   32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] normal[$];
    bit ok, prev_ok, busy_b, rstn_b;
    int r, n;

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.eop      = 1'b0;
    normal = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h42};

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    run_stream("normal", normal, 1'b0, 0, ok);
    release_run("normal");

    // eop held high through most of the load must be ignored.
    s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'h50};
    run_stream("reload", s, 1'b0, 4, ok);
    release_run("reload");

    run_stream("gaps", normal, 1'b1, 0, ok);
    release_run("gaps");

    // Abort inside DAT_HI with reset asserted between clock edges.
    send_byte(8'h02, 1'b0, 1'b0, busy_b, rstn_b);
    send_byte(8'h00, 1'b0, 1'b0, busy_b, rstn_b);
    send_byte(8'h34, 1'b0, 1'b0, busy_b, rstn_b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    @(negedge clk);
    rst_n = 1'b1;
    run_stream("post_async", normal, 1'b0, 0, ok);
    release_run("post_async");

    s = normal;
    s[6] = 8'h43;
    run_stream("bad_chk", s, 1'b0, 0, ok);

    do_reset();
    s = '{8'h00, 8'h00};
    run_stream("hdr_zero", s, 1'b0, 0, ok);

    do_reset();
    s = '{8'h01, 8'h01};
    run_stream("hdr_big", s, 1'b0, 0, ok);

    do_reset();
    make_stream(256, 256, 1'b0, s);
    run_stream("full", s, 1'b0, 0, ok);
    prev_ok = ok;

    for (int t = 0; t < 20; t++) begin
      if (prev_ok) release_run("rand");
      else do_reset();
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(257, 65535));
        make_stream(n, 0, 1'b0, s);
      end else begin
        n = int'($urandom_range(1, 12));
        make_stream(n, n, ($urandom_range(0, 3) == 0), s);
      end
      run_stream("rand", s, ($urandom_range(0, 1) == 1), 0, ok);
      prev_ok = ok;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
